// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > branch flush > load-use stall.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT_MAX = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic             dmem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] LD_STALL = 2'b01;
  localparam logic [1:0] MEM_WAIT = 2'b10;
  localparam logic [7:0] LAT_MAX  = 8'(MEM_LAT_MAX);

  logic [1:0] state, state_nxt;
  logic [7:0] wait_q, wait_nxt;
  logic       timeout_q;
  logic       hazard_lu, lu_en, freeze;

  assign hazard_lu = ex_memread & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  // In MEM_WAIT only the ack releases the freeze; LD_STALL masks load-use so each load-use costs one bubble.
  assign freeze = (state == MEM_WAIT) ? ~dmem_ack : (mem_access & ~dmem_ack);
  assign lu_en  = hazard_lu & (state != LD_STALL);

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    state_nxt   = RUN;
    if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      state_nxt   = MEM_WAIT;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu_en) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      state_nxt  = LD_STALL;
    end
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end
  end

  always_comb begin
    wait_nxt = wait_q;
    if (freeze) begin
      if (state != MEM_WAIT) wait_nxt = 8'd1;
      else if (wait_q != 8'hFF) wait_nxt = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wait_q <= wait_nxt;
      if (freeze && (wait_nxt >= LAT_MAX)) timeout_q <= 1'b1;
    end
  end

  assign state_o      = state;
  assign dmem_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_q, flush_q, waitc_q;

  // The entry cycle of a memory wait is frozen too, so it counts as wait rather than load-use stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      waitc_q <= '0;
    end else begin
      if (!pc_en && !freeze && stall_q != CNT_MAX) stall_q <= stall_q + 1'b1;
      if (freeze && waitc_q != CNT_MAX) waitc_q <= waitc_q + 1'b1;
      if (ifid_flush && flush_q != CNT_MAX) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign wait_cnt  = waitc_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl (built with MEM_LAT_MAX = 4).
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs2 = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0;
  logic mem_access = 1'b0, dmem_ack = 1'b0;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
  logic dmem_timeout;
  logic [1:0] state_o;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [6:0] ctl;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] C_DEF    = 7'b1101010;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_BR     = 7'b1111110;
  localparam logic [6:0] C_FRZ    = 7'b0000001;
  localparam logic [6:0] C_RST    = 7'b0010101;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
    logic       memread;
    logic [4:0] rd;
    logic       br;
    logic       macc;
    logic       ack;
    logic [6:0] ctl;
    logic [1:0] nxt;
  } vec_t;

  vec_t vecs[12];

  pipeline_hazard_ctrl #(.MEM_LAT_MAX(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_flush(memwb_flush), .dmem_timeout(dmem_timeout), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.uses_rs2;
    ex_memread = v.memread; ex_rd = v.rd; ex_branch_taken = v.br;
    mem_access = v.macc; dmem_ack = v.ack;
  endtask

  task automatic setIdle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; ex_memread = 1'b0; ex_rd = '0;
    ex_branch_taken = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    setIdle();
    rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  // Clock one edge and check the registered state shortly after it.
  task automatic stepCheckState(input string name, input logic [1:0] exp);
    @(posedge clk);
    #1 checkOutput(name, 32'(state_o), 32'(exp));
  endtask

  initial begin
    //            rs1 rs2 u2 mr  rd br ma ak  ctl    nxt
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, C_DEF, 2'b00};
    vecs[1]  = '{5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, C_LU,  2'b01};
    vecs[2]  = '{5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, C_DEF, 2'b00};
    vecs[3]  = '{5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0, C_LU,  2'b01};
    vecs[4]  = '{5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 0, C_DEF, 2'b00};
    vecs[5]  = '{5'd5, 5'd0, 0, 0, 5'd5, 0, 0, 0, C_DEF, 2'b00};
    vecs[6]  = '{5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 0, C_BR,  2'b00};
    vecs[7]  = '{5'd1, 5'd2, 1, 0, 5'd9, 1, 0, 0, C_BR,  2'b00};
    vecs[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, C_FRZ, 2'b10};
    vecs[9]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, C_DEF, 2'b00};
    vecs[10] = '{5'd4, 5'd0, 0, 1, 5'd4, 0, 1, 1, C_LU,  2'b01};
    vecs[11] = '{5'd4, 5'd0, 0, 1, 5'd4, 1, 1, 0, C_FRZ, 2'b10};

    // Reset values while rst is held
    #2;
    checkOutput("reset_ctl", 32'(ctl), 32'(C_RST));
    checkOutput("reset_state", 32'(state_o), 32'd0);
    checkOutput("reset_timeout", 32'(dmem_timeout), 32'd0);
    checkOutput("reset_cnts", stall_cnt | flush_cnt | wait_cnt, 32'd0);
    #1 rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      pulseReset();
      applyStimulus(vecs[i]);
      #1 checkOutput($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
      stepCheckState($sformatf("vec%0d_state", i), vecs[i].nxt);
    end

    // Load-use: exactly one bubble even if the hazard pattern is still present
    pulseReset();
    applyStimulus(vecs[1]);
    #1 checkOutput("lu_seq_stall", 32'(ctl), 32'(C_LU));
    stepCheckState("lu_seq_st1", 2'b01);
    @(negedge clk);
    checkOutput("lu_seq_masked", 32'(ctl), 32'(C_DEF));
    stepCheckState("lu_seq_st2", 2'b00);
`ifdef PIPE_PERF_CNT_EN
    checkOutput("lu_seq_stall_cnt", stall_cnt, 32'd1);
`endif

    // Memory wait of three frozen cycles; branch/load-use ignored until the ack cycle
    pulseReset();
    mem_access = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd6; id_rs1 = 5'd6;
      end
      #1 checkOutput($sformatf("mw_freeze%0d", c), 32'(ctl), 32'(C_FRZ));
      stepCheckState($sformatf("mw_state%0d", c), 2'b10);
      @(negedge clk);
    end
    dmem_ack = 1'b1;
    #1 checkOutput("mw_release", 32'(ctl), 32'(C_BR));
    stepCheckState("mw_back_run", 2'b00);
    checkOutput("mw_no_timeout", 32'(dmem_timeout), 32'd0);
`ifdef PIPE_PERF_CNT_EN
    checkOutput("mw_wait_cnt", wait_cnt, 32'd3);
`endif

    // Watchdog: sets after the 4th unacknowledged cycle, sticky across ack
    pulseReset();
    mem_access = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1 checkOutput($sformatf("wd_cycle%0d", c), 32'(dmem_timeout), (c == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    stepCheckState("wd_ack_state", 2'b00);
    @(negedge clk);
    setIdle();
    @(posedge clk);
    #1 checkOutput("wd_sticky", 32'(dmem_timeout), 32'd1);

    // Asynchronous reset in the middle of a memory wait
    pulseReset();
    mem_access = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("rmw_in_wait", 32'(state_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    checkOutput("rmw_ctl", 32'(ctl), 32'(C_RST));
    checkOutput("rmw_state", 32'(state_o), 32'd0);
    checkOutput("rmw_cnts", stall_cnt | flush_cnt | wait_cnt, 32'd0);
    setIdle();
    #1 rst = 1'b0;
    #1 checkOutput("rmw_after_ctl", 32'(ctl), 32'(C_DEF));
    stepCheckState("rmw_after_state", 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
